// File: rtl/pio_rsp_arb_if.sv
// rtl/pio_rsp_arb_if.sv - per-channel completion inputs and merged CC output of the PIO arbiter
`ifndef PIO_DATA_W
`define PIO_DATA_W 64
`endif

interface pio_rsp_arb_if #(
  parameter int CHANNEL_NUM = 6
);
  logic [CHANNEL_NUM*`PIO_DATA_W-1:0] s_axis_rsp_data;
  logic [CHANNEL_NUM*96-1:0]          s_axis_rsp_head;
  logic [CHANNEL_NUM-1:0]             s_axis_rsp_last;
  logic [CHANNEL_NUM-1:0]             s_axis_rsp_valid;
  logic [CHANNEL_NUM-1:0]             s_axis_rsp_ready;
  logic [`PIO_DATA_W-1:0]             m_axis_cc_tdata;
  logic [95:0]                        m_axis_cc_tuser;
  logic                               m_axis_cc_tlast;
  logic                               m_axis_cc_tvalid;
  logic                               m_axis_cc_tready;

  // Arbiter side.
  modport slave (
    input  s_axis_rsp_data, s_axis_rsp_head, s_axis_rsp_last, s_axis_rsp_valid,
    output s_axis_rsp_ready,
    output m_axis_cc_tdata, m_axis_cc_tuser, m_axis_cc_tlast, m_axis_cc_tvalid,
    input  m_axis_cc_tready
  );

  // Requester / downstream side.
  modport master (
    output s_axis_rsp_data, s_axis_rsp_head, s_axis_rsp_last, s_axis_rsp_valid,
    input  s_axis_rsp_ready,
    input  m_axis_cc_tdata, m_axis_cc_tuser, m_axis_cc_tlast, m_axis_cc_tvalid,
    output m_axis_cc_tready
  );
endinterface

// File: rtl/pio_rsp_arb.sv
// rtl/pio_rsp_arb.sv - round-robin, packet-atomic merge of PIO completion channels into the CC stream
`ifndef PIO_DATA_W
`define PIO_DATA_W 64
`endif

module pio_rsp_arb #(
  parameter int CHANNEL_NUM = 6,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pio_rsp_arb_if.slave     bus,
  output logic [CNT_W-1:0] cpl_cnt,
  output logic             arb_busy
);
  localparam int DW = `PIO_DATA_W;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               gnt, rr_ptr, scan_sel;
  logic                     scan_hit, first_flag;
  logic                     out_free, beat_acc, pkt_end;
  logic [DW-1:0]            sel_data;
  logic [95:0]              sel_head;
  logic                     sel_valid, sel_last;
  logic [2*CHANNEL_NUM-1:0] valid_dbl;
  logic [CHANNEL_NUM-1:0]   valid_rot;
  int                       scan_idx;

  // Rotating the request vector by rr_ptr turns the round-robin scan into a priority scan from bit 0.
  always_comb begin
    valid_dbl = {bus.s_axis_rsp_valid, bus.s_axis_rsp_valid} >> rr_ptr;
    valid_rot = valid_dbl[CHANNEL_NUM-1:0];
    scan_hit  = 1'b0;
    scan_sel  = 3'd0;
    scan_idx  = 0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      if (!scan_hit && valid_rot[k]) begin
        scan_hit = 1'b1;
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= CHANNEL_NUM) scan_idx = scan_idx - CHANNEL_NUM;
        scan_sel = scan_idx[2:0];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_head  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (gnt == 3'(i)) begin
        sel_data  = bus.s_axis_rsp_data[i*DW +: DW];
        sel_head  = bus.s_axis_rsp_head[i*96 +: 96];
        sel_valid = bus.s_axis_rsp_valid[i];
        sel_last  = bus.s_axis_rsp_last[i];
      end
    end
  end

  assign out_free = !bus.m_axis_cc_tvalid || bus.m_axis_cc_tready;
  assign beat_acc = (state == LOCK) && sel_valid && out_free;
  assign pkt_end  = beat_acc && sel_last;
  assign arb_busy = (state == LOCK);

  always_comb begin
    bus.s_axis_rsp_ready = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      bus.s_axis_rsp_ready[i] = (state == LOCK) && (gnt == 3'(i)) && out_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_hit) state_nxt = LOCK;
      LOCK:    if (pkt_end)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= 3'd0;
      rr_ptr     <= 3'd0;
      first_flag <= 1'b1;
    end else begin
      if (state == IDLE && scan_hit) gnt <= scan_sel;
      if (pkt_end) begin
        rr_ptr     <= (gnt == 3'(CHANNEL_NUM-1)) ? 3'd0 : gnt + 3'd1;
        first_flag <= 1'b1;
      end else if (beat_acc) begin
        first_flag <= 1'b0;
      end
    end
  end

  // tuser is captured once per packet so it stays constant across all its beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_axis_cc_tdata  <= '0;
      bus.m_axis_cc_tuser  <= '0;
      bus.m_axis_cc_tlast  <= 1'b0;
      bus.m_axis_cc_tvalid <= 1'b0;
    end else if (beat_acc) begin
      bus.m_axis_cc_tdata  <= sel_data;
      bus.m_axis_cc_tlast  <= sel_last;
      bus.m_axis_cc_tvalid <= 1'b1;
      if (first_flag) bus.m_axis_cc_tuser <= sel_head;
    end else if (bus.m_axis_cc_tready) begin
      bus.m_axis_cc_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_cnt <= '0;
    end else if (bus.m_axis_cc_tvalid && bus.m_axis_cc_tready && bus.m_axis_cc_tlast) begin
      cpl_cnt <= cpl_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pio_rsp_arb.sv
// tb/tb_pio_rsp_arb.sv - scoreboard bench for pio_rsp_arb with a packet-level round-robin model
`ifndef PIO_DATA_W
`define PIO_DATA_W 64
`endif

module tb_pio_rsp_arb;
  localparam int CH = 6;
  localparam int DW = `PIO_DATA_W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [95:0]   head;
    logic          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpl_cnt;
  logic        arb_busy;

  pio_rsp_arb_if #(.CHANNEL_NUM(CH)) bus ();

  pio_rsp_arb #(.CHANNEL_NUM(CH), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpl_cnt  (cpl_cnt),
    .arb_busy (arb_busy)
  );

  always #5 clk = ~clk;

  beat_t         chq [CH][$];
  beat_t         expq[$];
  int            out_cyc[$];
  bit            tq[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            mon_pops = 0;
  int            model_rr = 0;
  int            model_cnt = 0;
  int            sub_cyc = 0;
  bit            rnd_rdy = 1'b0;
  int            hold_at[CH] = '{default: 0};
  int            hold_len[CH] = '{default: 0};
  int            hold_used[CH] = '{default: 0};
  logic [CH-1:0] acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Requester model: each channel presents the head of its beat queue, optionally stalling mid-packet.
  initial begin
    bus.s_axis_rsp_valid = '0;
    bus.s_axis_rsp_data  = '0;
    bus.s_axis_rsp_head  = '0;
    bus.s_axis_rsp_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++)
        if (acc[c] && chq[c].size() > 0) void'(chq[c].pop_front());
      for (int c = 0; c < CH; c++) begin
        if (chq[c].size() == 0) hold_used[c] = 0;
        if (chq[c].size() > 0 && hold_len[c] > 0 && chq[c].size() == hold_at[c] &&
            hold_used[c] < hold_len[c]) begin
          bus.s_axis_rsp_valid[c] = 1'b0;
          hold_used[c]++;
        end else if (chq[c].size() > 0) begin
          bus.s_axis_rsp_valid[c]          = 1'b1;
          bus.s_axis_rsp_data[c*DW +: DW]  = chq[c][0].data;
          bus.s_axis_rsp_head[c*96 +: 96]  = chq[c][0].head;
          bus.s_axis_rsp_last[c]           = chq[c][0].last;
        end else begin
          bus.s_axis_rsp_valid[c] = 1'b0;
          bus.s_axis_rsp_last[c]  = 1'b0;
        end
      end
    end
  end

  // Downstream model: tready from a pattern queue, random, or constantly high.
  initial begin
    bus.m_axis_cc_tready = 1'b1;
    forever begin
      @(negedge clk);
      if (tq.size() > 0)  bus.m_axis_cc_tready = tq.pop_front();
      else if (rnd_rdy)   bus.m_axis_cc_tready = ($urandom_range(0, 3) != 0);
      else                bus.m_axis_cc_tready = 1'b1;
      #2;
      acc = bus.s_axis_rsp_valid & bus.s_axis_rsp_ready;
    end
  end

  // Monitor: every accepted output beat must be the next one the model predicted.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("ready_onehot", 128'($onehot0(bus.s_axis_rsp_ready)), 128'd1);
        if (bus.m_axis_cc_tvalid && !bus.m_axis_cc_tready)
          chk("ready_when_stalled", 128'(bus.s_axis_rsp_ready), 128'd0);
        if (bus.m_axis_cc_tvalid && bus.m_axis_cc_tready) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %h with empty scoreboard", bus.m_axis_cc_tdata);
          end else begin
            e = expq.pop_front();
            chk("tdata", 128'(bus.m_axis_cc_tdata), 128'(e.data));
            chk("tuser", 128'(bus.m_axis_cc_tuser), 128'(e.head));
            chk("tlast", 128'(bus.m_axis_cc_tlast), 128'(e.last));
          end
          out_cyc.push_back(cyc);
          mon_pops++;
        end
      end
    end
  end

  // One packet per masked channel, all raised together; served order is a round-robin walk from model_rr.
  task automatic submit(input logic [CH-1:0] mask, input int fixed_len);
    beat_t bt, ex;
    int    idx, len, served;
    logic [95:0] head;
    @(negedge clk);
    sub_cyc = cyc + 1;
    served = -1;
    for (int k = 0; k < CH; k++) begin
      idx = (model_rr + k) % CH;
      if (mask[idx]) begin
        len  = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
        head = {$urandom, $urandom, $urandom};
        for (int b = 0; b < len; b++) begin
          bt.data = {$urandom, $urandom};
          bt.last = (b == len - 1);
          bt.head = (b == 0) ? head : {$urandom, $urandom, $urandom};
          chq[idx].push_back(bt);
          ex      = bt;
          ex.head = head;
          expq.push_back(ex);
        end
        served = idx;
        model_cnt++;
      end
    end
    if (served >= 0) model_rr = (served + 1) % CH;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (expq.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (expq.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_%s: %0d beats outstanding, required 0", tag, expq.size());
      expq.delete();
      for (int c = 0; c < CH; c++) chq[c].delete();
    end
    repeat (2) @(negedge clk);
    chk({"cpl_cnt_", tag}, 128'(cpl_cnt), 128'(model_cnt));
    chk({"busy_idle_", tag}, 128'(arb_busy), 128'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({"rst_tvalid_", tag}, 128'(bus.m_axis_cc_tvalid), 128'd0);
    chk({"rst_tlast_", tag},  128'(bus.m_axis_cc_tlast), 128'd0);
    chk({"rst_tdata_", tag},  128'(bus.m_axis_cc_tdata), 128'd0);
    chk({"rst_tuser_", tag},  128'(bus.m_axis_cc_tuser), 128'd0);
    chk({"rst_ready_", tag},  128'(bus.s_axis_rsp_ready), 128'd0);
    chk({"rst_cnt_", tag},    128'(cpl_cnt), 128'd0);
    chk({"rst_busy_", tag},   128'(arb_busy), 128'd0);
  endtask

  initial begin
    int t, base;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Channels 0, 2, 5 with single-beat packets: order 0,2,5 and one packet every two cycles.
    out_cyc.delete();
    submit(6'b100101, 1);
    drain("rr_wrap");
    if (out_cyc.size() == 3) begin
      chk("gap_0_2", 128'(out_cyc[1] - out_cyc[0]), 128'd2);
      chk("gap_2_5", 128'(out_cyc[2] - out_cyc[1]), 128'd2);
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL rr_wrap_beats: got %0d required 3", out_cyc.size());
    end

    // Channel 1 three beats with channel 4 pending: no interleave.
    submit(6'b010010, 3);
    drain("no_interleave");

    // Channel 3 alone, four beats: first output two cycles after valid rises.
    out_cyc.delete();
    submit(6'b001000, 4);
    drain("latency");
    if (out_cyc.size() == 4) begin
      chk("first_beat_cycle", 128'(out_cyc[0]), 128'(sub_cyc + 2));
      chk("last_beat_cycle",  128'(out_cyc[3]), 128'(sub_cyc + 5));
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL latency_beats: got %0d required 4", out_cyc.size());
    end

    // Backpressure during a four-beat packet.
    submit(6'b000001, 4);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) tq.push_back(i % 3 == 0);
    drain("stall");

    // Channel 2 stalls for five cycles after its first beat while channel 0 waits.
    hold_at[2]  = 3;
    hold_len[2] = 5;
    submit(6'b000101, 4);
    t = 0;
    while (hold_used[2] == 0 && t < 50) begin @(negedge clk); t++; end
    while (hold_used[2] < 5 && t < 50) begin
      @(negedge clk);
      #3;
      chk("busy_during_hold", 128'(arb_busy), 128'd1);
      chk("ch0_blocked", 128'(bus.s_axis_rsp_ready[0]), 128'd0);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL hold_window: got timeout required 5 stalled cycles");
    end
    drain("hold");
    hold_len[2] = 0;

    // Move rr_ptr off zero, then reset in the middle of a packet.
    submit(6'b000100, 1);
    drain("pre_reset");
    base = mon_pops;
    submit(6'b001000, 4);
    t = 0;
    while (mon_pops < base + 2 && t < 100) begin @(negedge clk); #3; t++; end
    rst_n = 1'b0;
    expq.delete();
    for (int c = 0; c < CH; c++) chq[c].delete();
    model_rr  = 0;
    model_cnt = 0;
    @(negedge clk);
    chk_reset_outputs("mid_pkt");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    submit(6'b010010, 1);
    drain("post_reset");

    // Randomised rounds with random tready.
    rnd_rdy = 1'b1;
    for (int r = 0; r < 40; r++) begin
      submit(CH'($urandom_range(1, (1 << CH) - 1)), 0);
      drain("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pio_rsp_arb.md
# pio_rsp_arb

Round-robin completion arbiter for the PIO path. It merges per-channel completion streams (HCR CFG, Ethernet, HCA MSI-X, P2P CFG, P2P MEM, UAR) into the single PCIe completer-completion stream. Packets are never interleaved: a grant is held until the end of its packet. The block sits downstream of the per-channel PIO targets and upstream of the CC formatter. It registers its output and keeps a completion count for debug.

## Interface
Parameters:
- CHANNEL_NUM, 6, number of completion requesters; valid range 2..8.
- CNT_W, 32, width of the completed-packet counter.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  asynchronous, active-low reset.
- s_axis_rsp_data  input  CHANNEL_NUM*`PIO_DATA_W  per-channel beat data; channel i occupies slice i.
- s_axis_rsp_head  input  CHANNEL_NUM*96  per-channel cc_head; only sampled on a packet's first beat.
- s_axis_rsp_last  input  CHANNEL_NUM  per-channel end-of-packet.
- s_axis_rsp_valid  input  CHANNEL_NUM  per-channel beat valid.
- s_axis_rsp_ready  output  CHANNEL_NUM  per-channel beat accept; at most one bit is high at a time.
- m_axis_cc_tdata  output  `PIO_DATA_W  merged beat data.
- m_axis_cc_tuser  output  96  cc_head of the current packet; held for every beat of the packet.
- m_axis_cc_tlast  output  1  end-of-packet.
- m_axis_cc_tvalid  output  1  beat valid.
- m_axis_cc_tready  input  1  downstream accept.
- cpl_cnt  output  CNT_W  number of packets fully forwarded; wraps at 2^CNT_W.
- arb_busy  output  1  high while in the LOCK state.

## Operation
- FSM states:
  - IDLE: no grant held.
  - LOCK: grant register gnt (3 bits) owns the output.
- IDLE:
  - If any s_axis_rsp_valid bit is set, select the first set channel scanning from rr_ptr upward, modulo CHANNEL_NUM.
  - Register the selection in gnt and go to LOCK next cycle.
  - No input beat is accepted in IDLE.
- LOCK:
  - s_axis_rsp_ready[gnt] = out_free, where out_free = !m_axis_cc_tvalid | m_axis_cc_tready. All other ready bits are 0.
  - An accepted beat loads the output register: data, last, valid=1.
  - If the beat is the first of its packet (first_flag=1), it also loads tuser from the head slice of gnt, and first_flag clears.
- End of packet: on acceptance of a beat with last=1:
  - rr_ptr <= (gnt+1) mod CHANNEL_NUM.
  - first_flag <= 1.
  - FSM returns to IDLE.
- Output register: m_axis_cc_tvalid clears when m_axis_cc_tready=1 and no new beat is loaded in the same cycle.
- cpl_cnt increments by 1 when m_axis_cc_tvalid & m_axis_cc_tready & m_axis_cc_tlast.
- Boundary conditions:
  - If the granted channel drops valid mid-packet, the grant is held (no timeout), and no other channel is served.
  - Single-beat packets (last on the first beat) are legal.
  - A requester that deasserts valid before it is granted is skipped. The scan runs fresh each IDLE cycle.
  - Wrap: rr_ptr = CHANNEL_NUM-1 followed by a packet end gives rr_ptr = 0.
  - Simultaneous output load and output drain in one cycle keeps tvalid=1 with the new beat.
- Reset mid-packet: the partial packet is abandoned. The downstream never sees its remaining beats, and no recovery is attempted.

## Timing
- Reset values:
  - state=IDLE, gnt=0, rr_ptr=0, first_flag=1.
  - m_axis_cc_tvalid=0, m_axis_cc_tlast=0, m_axis_cc_tdata=0, m_axis_cc_tuser=0.
  - s_axis_rsp_ready=0, cpl_cnt=0, arb_busy=0.
- Latency: valid rises in cycle 0 (IDLE) → grant in cycle 1, where the first beat is accepted if out_free → m_axis_cc_tvalid in cycle 2.
- Throughput: 1 beat/cycle within a packet. There is exactly 1 idle arbitration cycle between packets.
- s_axis_rsp_ready depends combinationally on m_axis_cc_tready. No other input-to-output combinational paths exist.
- Output signals are stable while tvalid=1 and tready=0.

## Test plan
- Single channel 3, 4-beat packet, tready=1 → ready[3] high in cycles 1-4; output beats in cycles 2-5 with tuser = channel 3 head; tlast on beat 4; cpl_cnt=1.
- Channels 0, 2 and 5 all valid with 1-beat packets, rr_ptr=0 → output order 0, 2, 5, one packet every 2 cycles; rr_ptr ends at 0 (wrap from 5).
- Channel 1 sends 3 beats while channel 4 is valid → no channel 4 beat appears until channel 1's tlast; outputs are never interleaved.
- tready toggles 1,0,0,1 during a 4-beat packet → tdata/tuser held while stalled; no beat lost or duplicated; ready[gnt]=0 only when tvalid=1 and tready=0.
- rst_n asserted after beat 2 of a 4-beat packet, then released → all outputs at reset values; next request is granted from rr_ptr=0; cpl_cnt=0.
- Channel 2 drops valid after beat 1 for 5 cycles while channel 0 is valid → arb_busy stays 1, no channel 0 beat is accepted, and channel 2 completes on resume.
